// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two frame sources, the arbiter and the UART transmitter.
interface uart_tx_arbiter_if #(
    parameter int unsigned BYTE_W = 8
);
    logic                  req0;
    logic [2*BYTE_W-1:0]   data0;
    logic                  ack0;
    logic                  req1;
    logic [BYTE_W-1:0]     data1;
    logic                  ack1;
    logic                  tx_busy;
    logic [BYTE_W-1:0]     tx_p_data;
    logic                  tx_data_valid;
    logic                  arb_busy;
    logic                  grant_id;

    modport master (
        output req0, data0, req1, data1, tx_busy,
        input  ack0, ack1, tx_p_data, tx_data_valid, arb_busy, grant_id
    );

    modport slave (
        input  req0, data0, req1, data1, tx_busy,
        output ack0, ack1, tx_p_data, tx_data_valid, arb_busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises a 2-byte channel-0 frame and a 1-byte
// channel-1 frame into a single UART transmitter, paced by its busy flag.
module uart_tx_arbiter #(
    parameter int unsigned BYTE_W   = 8,
    parameter int unsigned WAIT_MAX = 4
) (
    input logic              CLK,
    input logic              RST,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned FRAME_W = 2 * BYTE_W;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned WAIT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                grant_q, grant_d;
    logic [BYTE_W-1:0]   pdata_q, pdata_d;
    logic                valid_q, valid_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                busy_q;
    logic                pick;

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        grant_d = grant_q;
        pdata_d = pdata_q;
        valid_d = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        pick    = (bus.req0 && bus.req1) ? ~grant_q : bus.req1;

        case (state_q)
            IDLE: begin
                if (!bus.tx_busy && (bus.req0 || bus.req1)) begin
                    grant_d = pick;
                    cnt_d   = pick ? CNT_W'(1) : CNT_W'(2);
                    shift_d = pick ? FRAME_W'(bus.data1) : bus.data0;
                    pdata_d = pick ? bus.data1 : bus.data0[BYTE_W-1:0];
                    valid_d = 1'b1;
                    ack0_d  = ~pick;
                    ack1_d  = pick;
                    state_d = SEND;
                end
            end
            SEND: begin
                wait_d  = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else begin
                    // Transmitter ignored the strobe: re-issue the same byte.
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_W'(WAIT_MAX)) begin
                        valid_d = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d != '0) begin
                        shift_d = shift_q >> BYTE_W;
                        pdata_d = shift_q[FRAME_W-1:BYTE_W];
                        valid_d = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            grant_q <= 1'b1;
            pdata_q <= '0;
            valid_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            grant_q <= grant_d;
            pdata_q <= pdata_d;
            valid_q <= valid_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.ack0          = ack0_q;
    assign bus.ack1          = ack1_q;
    assign bus.tx_p_data     = pdata_q;
    assign bus.tx_data_valid = valid_q;
    assign bus.arb_busy      = busy_q;
    assign bus.grant_id      = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a simple busy-flag transmitter model.
module tb_uart_tx_arbiter;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned WAIT_MAX = 4;
    localparam int          BUSY_LEN = 11;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_arbiter_if #(.BYTE_W(BYTE_W)) bus ();

    uart_tx_arbiter #(.BYTE_W(BYTE_W), .WAIT_MAX(WAIT_MAX)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int strobe_cnt = 0;

    logic [BYTE_W-1:0] byte_q[$];
    logic [1:0]        ack_q[$];

    bit   tx_auto   = 1'b1;
    logic force_val = 1'b0;
    logic busy_m;
    int   busy_left;

    assign bus.tx_busy = tx_auto ? busy_m : force_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy rises the cycle after an accepted strobe for BUSY_LEN cycles.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy_m    <= 1'b0;
            busy_left <= 0;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) busy_m <= 1'b0;
        end else if (tx_auto && bus.tx_data_valid) begin
            busy_m    <= 1'b1;
            busy_left <= BUSY_LEN;
        end
    end

    // Scoreboard monitor for strobed bytes and acks.
    always @(negedge CLK) begin
        if (RST) begin
            if (bus.tx_data_valid) begin
                strobe_cnt++;
                check("byte_expected", 32'(byte_q.size() != 0), 32'(1));
                if (byte_q.size() != 0) begin
                    check("tx_p_data", 32'(bus.tx_p_data), 32'(byte_q[0]));
                    if (tx_auto) void'(byte_q.pop_front());
                end
            end
            if (bus.ack0 || bus.ack1) begin
                check("ack_expected", 32'(ack_q.size() != 0), 32'(1));
                if (ack_q.size() != 0) begin
                    check("ack_channel", 32'({bus.ack1, bus.ack0}), 32'(ack_q[0]));
                    void'(ack_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((bus.arb_busy || bus.tx_busy) && n < 300) begin
            @(posedge CLK); #1; n++;
        end
        check(tag, 32'(bus.arb_busy), 32'(0));
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!bus.tx_data_valid && n < 100);
    endtask

    task automatic wait_ack(output logic [1:0] acks);
        int n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!(bus.ack0 || bus.ack1) && n < 300);
        acks = {bus.ack1, bus.ack0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         s0;
        logic [1:0] acks;

        bus.req0 = 1'b0; bus.data0 = '0;
        bus.req1 = 1'b0; bus.data1 = '0;
        #12;
        check("rst_valid", 32'(bus.tx_data_valid), 32'(0));
        check("rst_ack0", 32'(bus.ack0), 32'(0));
        check("rst_ack1", 32'(bus.ack1), 32'(0));
        check("rst_arb_busy", 32'(bus.arb_busy), 32'(0));
        check("rst_pdata", 32'(bus.tx_p_data), 32'(0));
        check("rst_grant", 32'(bus.grant_id), 32'(1));
        @(posedge CLK); #1 RST = 1'b1;

        // 1: single channel-1 byte
        @(posedge CLK); #1;
        s0 = strobe_cnt;
        ack_q.push_back(2'b10); byte_q.push_back(8'hA5);
        bus.data1 = 8'hA5; bus.req1 = 1'b1;
        @(posedge CLK); #1;
        check("t1_ack1_latency", 32'(bus.ack1), 32'(1));
        check("t1_strobe_latency", 32'(bus.tx_data_valid), 32'(1));
        bus.req1 = 1'b0;
        n = 0;
        while (bus.arb_busy && n < 50) begin @(posedge CLK); #1; n++; end
        check("t1_busy_span", 32'(n), 32'(BUSY_LEN + 2));
        check("t1_strobes", 32'(strobe_cnt - s0), 32'(1));
        check("t1_grant", 32'(bus.grant_id), 32'(1));

        // 2: two-byte channel-0 frame, LSB first
        @(posedge CLK); #1;
        ack_q.push_back(2'b01); byte_q.push_back(8'h7E); byte_q.push_back(8'h3C);
        bus.data0 = 16'h3C7E; bus.req0 = 1'b1;
        @(posedge CLK); #1;
        check("t2_ack0_latency", 32'(bus.ack0), 32'(1));
        check("t2_first_byte", 32'(bus.tx_p_data), 32'(8'h7E));
        bus.req0 = 1'b0;
        wait_strobe(n);
        check("t2_second_strobe_gap", 32'(n), 32'(BUSY_LEN + 2));
        check("t2_second_byte", 32'(bus.tx_p_data), 32'(8'h3C));
        check("t2_no_second_ack", 32'(bus.ack0), 32'(0));
        check("t2_grant", 32'(bus.grant_id), 32'(0));
        wait_idle("t2_idle");

        // 3: contention from reset with continuous re-requests
        bus.data0 = 16'h1234; bus.data1 = 8'h56;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ack_q.push_back(2'b01); byte_q.push_back(8'h34); byte_q.push_back(8'h12);
            ack_q.push_back(2'b10); byte_q.push_back(8'h56);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_ack(acks);
            check("t3_ack_order", 32'(acks), (i % 2 == 1) ? 32'(2'b10) : 32'(2'b01));
            check("t3_grant_order", 32'(bus.grant_id), 32'(i % 2));
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_idle("t3_idle");
        check("t3_bytes_drained", 32'(byte_q.size()), 32'(0));

        // 4: transmitter never raises busy -> periodic retry of the same byte
        tx_auto = 1'b0; force_val = 1'b0;
        ack_q.push_back(2'b10); byte_q.push_back(8'hC3);
        bus.data1 = 8'hC3; bus.req1 = 1'b1;
        @(posedge CLK); #1;
        check("t4_ack1", 32'(bus.ack1), 32'(1));
        bus.req1 = 1'b0;
        for (int r = 0; r < 2; r++) begin
            wait_strobe(n);
            check("t4_retry_period", 32'(n), 32'(WAIT_MAX + 1));
            check("t4_retry_byte", 32'(bus.tx_p_data), 32'(8'hC3));
            check("t4_retry_no_ack", 32'(bus.ack1), 32'(0));
        end
        tx_auto = 1'b1;
        wait_idle("t4_recover_idle");
        check("t4_bytes_drained", 32'(byte_q.size()), 32'(0));

        // 5: reset while channel 0 first byte is in WAIT_LO
        @(posedge CLK); #1;
        ack_q.push_back(2'b01); byte_q.push_back(8'hEF);
        bus.data0 = 16'hBEEF; bus.req0 = 1'b1;
        @(posedge CLK); #1;
        check("t5_ack0", 32'(bus.ack0), 32'(1));
        bus.req0 = 1'b0;
        repeat (4) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus.tx_data_valid), 32'(0));
        check("t5_rst_arb_busy", 32'(bus.arb_busy), 32'(0));
        check("t5_rst_pdata", 32'(bus.tx_p_data), 32'(0));
        check("t5_rst_acks", 32'({bus.ack1, bus.ack0}), 32'(0));
        check("t5_rst_grant", 32'(bus.grant_id), 32'(1));
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        s0 = strobe_cnt;
        @(posedge CLK); #1;
        ack_q.push_back(2'b10); byte_q.push_back(8'h99);
        bus.data1 = 8'h99; bus.req1 = 1'b1;
        @(posedge CLK); #1;
        check("t5_ack1_after_reset", 32'(bus.ack1), 32'(1));
        bus.req1 = 1'b0;
        wait_idle("t5_idle");
        check("t5_strobes", 32'(strobe_cnt - s0), 32'(1));

        // 6: transmitter owned elsewhere while a request waits
        tx_auto = 1'b0; force_val = 1'b1;
        ack_q.push_back(2'b10); byte_q.push_back(8'h42);
        @(posedge CLK); #1;
        bus.data1 = 8'h42; bus.req1 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #1;
            check("t6_hold_off", 32'({bus.ack1, bus.tx_data_valid, bus.arb_busy}), 32'(0));
        end
        force_val = 1'b0; tx_auto = 1'b1;
        @(posedge CLK); #1;
        check("t6_grant_ack", 32'(bus.ack1), 32'(1));
        check("t6_grant_strobe", 32'(bus.tx_data_valid), 32'(1));
        bus.req1 = 1'b0;
        wait_idle("t6_idle");

        check("final_bytes_empty", 32'(byte_q.size()), 32'(0));
        check("final_acks_empty", 32'(ack_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between two frame sources and sequences their bytes into it.
- Channel 0 carries a 16-bit result, sent as 2 bytes, LSB first.
- Channel 1 carries an 8-bit register read-back, sent as 1 byte.
- Round-robin arbitration between the two channels.
- Drives the transmitter's parallel byte and valid strobe, paced by the transmitter's busy flag.
- Sits between the system controller datapath and the UART TX.

Parameters:
BYTE_W, 8, width of one transmitted byte
WAIT_MAX, 4, cycles to wait for tx_busy to rise after a strobe before re-issuing the same byte (range 1..15)

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RST  input  1  asynchronous, active-low reset
req0  input  1  channel 0 frame request; held high until ack0
data0  input  2*BYTE_W  channel 0 frame; must be stable while req0 is high
ack0  output  1  one-cycle pulse when the channel 0 frame is captured
req1  input  1  channel 1 frame request; held high until ack1
data1  input  BYTE_W  channel 1 frame; must be stable while req1 is high
ack1  output  1  one-cycle pulse when the channel 1 frame is captured
tx_busy  input  1  transmitter busy flag
tx_p_data  output  BYTE_W  byte presented to the transmitter
tx_data_valid  output  1  one-cycle transmit strobe
arb_busy  output  1  high whenever a frame is held (state not IDLE)
grant_id  output  1  channel owning the current or most recent frame

Behaviour:
- Reset (RST=0, asynchronous) values:
  - state = IDLE; tx_data_valid, ack0, ack1, arb_busy = 0.
  - tx_p_data = 0; grant_id = 1, so channel 0 wins the first contention.
  - Byte counter and wait counter = 0.
  - A frame in flight is dropped with no ack and no further strobes.
- All outputs are registered or decoded from registered state only; no combinational path from input to output.
- IDLE:
  - Grant only when tx_busy=0 and (req0 | req1).
  - Both requesting: grant the channel != grant_id. One requesting: grant it.
  - On the granting edge:
    - Capture the frame into the shift register; byte count = 2 (ch0) or 1 (ch1).
    - Update grant_id; move to SEND.
- SEND (exactly 1 cycle):
  - tx_data_valid=1; tx_p_data = current byte (ch0: data0[7:0] first, then data0[15:8]).
  - ack of the granted channel = 1 in the first SEND cycle of a frame only.
  - Clear the wait counter; go to WAIT_HI.
- WAIT_HI:
  - tx_busy=1: go to WAIT_LO.
  - Otherwise increment the wait counter. When it reaches WAIT_MAX with tx_busy still 0, return to SEND with the same byte (retry, no ack).
- WAIT_LO:
  - Hold until tx_busy=0.
  - Then decrement the byte count. Nonzero: shift to the next byte and go to SEND. Zero: go to IDLE.
- tx_p_data holds its value from SEND until WAIT_LO exits. It is not cleared on return to IDLE.
- Latency:
  - req sampled high in IDLE at edge N gives ack plus the first strobe in cycle N+1.
  - Next byte strobe comes 1 cycle after tx_busy falls.
- Requests:
  - A req still high the cycle after its ack counts as a new frame, arbitrated from IDLE.
  - Requests arriving during a frame wait; they are never lost or merged.
- tx_busy already high in IDLE (the transmitter is owned elsewhere): no grant until it falls.
- A tx_busy glitch low for 1 cycle in WAIT_LO is treated as frame-byte completion. tx_busy must be clean.

Test Plan:
1. req1=1, data1=8'hA5, tx_busy model rises 1 cycle after the strobe and stays high 11 cycles -> ack1 and a single strobe with tx_p_data=A5 one cycle after the req edge; IDLE after busy falls; arb_busy high throughout.
2. req0=1, data0=16'h3C7E -> ack0 once; strobe with 7E, then a second strobe with 3C exactly 1 cycle after busy falls; grant_id=0.
3. req0 and req1 high together from reset, each re-requested immediately after its ack -> grant order ch0, ch1, ch0, ch1; no back-to-back grant to one channel while the other waits.
4. tx_busy held 0 after the strobe -> strobe repeats every WAIT_MAX+1 cycles with the same byte; no second ack; recovers when busy is finally driven.
5. RST asserted low during the WAIT_LO of ch0 byte 1 -> all outputs 0 in the same cycle, grant_id=1; after release a new req1 is served normally and no stale ch0 byte is sent.
6. tx_busy=1 in IDLE with req1=1 -> no ack or strobe until tx_busy=0; grant on the next edge.
